// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter and its address decoder:
// access size encodings, the memory map (DMEM window and UART TX address),
// and the access_t bundle describing one requester's access.
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Access size encodings as carried on mN_size / mem_*_size. 2'b11 is illegal.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Memory map defaults.
  localparam logic [31:0] DMEM_BASE      = 32'h1000_0000;
  localparam int          DMEM_SIZE_LOG2 = 17;
  localparam logic [31:0] UART_ADDR      = 32'h2000_0000;

  // One access as presented by a requester.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_signed;
  } access_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester port of the data-memory arbiter.
//   req/we/addr/wdata/size/sgn/lock : request, held stable by the requester
//                                     until gnt
//   gnt                             : request accepted this cycle
//   rvalid/rdata/err                : response, one cycle after the grant
// modport master : the requester (load/store unit, loader, DMA)
// modport slave  : the arbiter
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sgn;
  logic        lock;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, size, sgn, lock,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, size, sgn, lock,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_addr_check.sv
// -----------------------------------------------------------------------------
// dmem_addr_check
// Purely combinational legality check and decode for one access.
//   addr    in  32  byte address
//   size    in   2  access size (SZ_B/SZ_H/SZ_W)
//   we      in   1  1=store, 0=load
//   in_dmem out  1  address falls in the DMEM window
//   is_uart out  1  address is the UART TX register
//   err     out  1  access must be rejected (unmapped, UART load, bad size,
//                   misaligned half/word)
// -----------------------------------------------------------------------------
module dmem_addr_check
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h1000_0000,
  parameter int          SIZE_LOG2 = 17,
  parameter logic [31:0] UART      = 32'h2000_0000
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        we,
  output logic        in_dmem,
  output logic        is_uart,
  output logic        err
);

  logic bad_size;
  logic misaligned;

  // The DMEM window is naturally aligned, so only the bits above the window
  // size need to match the base.
  assign in_dmem = (addr[31:SIZE_LOG2] == BASE[31:SIZE_LOG2]);
  assign is_uart = (addr == UART);

  assign bad_size   = (size == 2'b11);
  assign misaligned = ((size == SZ_H) && addr[0]) ||
                      ((size == SZ_W) && (addr[1:0] != 2'b00));

  assign err = (!in_dmem && !is_uart) || (is_uart && !we) || bad_size || misaligned;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester round-robin arbiter in front of the single-ported DMEM/UART
// block, with per-port lock for read-modify-write sequences. Illegal accesses
// are granted but never issued; they complete with err.
//   clk, rst         : clock, asynchronous active-high reset
//   m0, m1           : requester ports (m0 = load/store unit, m1 = loader/DMA)
//   mem_read/write   : memory strobes, asserted in the grant cycle
//   mem_addr/wdata   : address and right-aligned store data of the winner
//   mem_load_signed, mem_load_size, mem_store_size : access qualifiers
//   mem_rdata        : load data, valid during the response cycle
// A one-stage response pipeline returns rvalid/rdata/err to the granted port
// one cycle after the grant.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter logic [31:0] DMEM_BASE      = dmem_pkg::DMEM_BASE,
  parameter int          DMEM_SIZE_LOG2 = dmem_pkg::DMEM_SIZE_LOG2,
  parameter logic [31:0] UART_ADDR      = dmem_pkg::UART_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        m0,
  dmem_arbiter_if.slave        m1,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_load_signed,
  output logic [1:0]           mem_load_size,
  output logic [1:0]           mem_store_size,
  input  logic [31:0]          mem_rdata
);

  // Arbitration state.
  logic rr_ptr;       // port that wins the next contended cycle
  logic lock_valid;   // a lock is held
  logic lock_port;    // port holding the lock

  // Response pipeline stage.
  logic resp_valid;
  logic resp_port;
  logic resp_load;
  logic resp_err;

  // Grant decision.
  logic                 gnt_valid;
  logic                 gnt_port;
  logic [1:0]           req;
  dmem_pkg::access_t    win;
  logic                 win_lock;

  logic chk_in_dmem;
  logic chk_is_uart;
  logic chk_err;
  logic issue;

  assign req = {m1.req, m0.req};

  // NOTE: every signal assigned in an always_comb gets a default at the top
  // so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    if (!rst) begin
      if (lock_valid && req[lock_port]) begin
        gnt_valid = 1'b1;
        gnt_port  = lock_port;
      end else begin
        unique case (req)
          2'b01:   begin gnt_valid = 1'b1; gnt_port = 1'b0;   end
          2'b10:   begin gnt_valid = 1'b1; gnt_port = 1'b1;   end
          2'b11:   begin gnt_valid = 1'b1; gnt_port = rr_ptr; end
          default: begin gnt_valid = 1'b0; gnt_port = 1'b0;   end
        endcase
      end
    end
  end

  // Winner's access. When idle this still selects m0; nothing downstream
  // looks at it unless gnt_valid is set.
  always_comb begin
    if (gnt_port) begin
      win      = '{we: m1.we, addr: m1.addr, wdata: m1.wdata, size: m1.size, is_signed: m1.sgn};
      win_lock = m1.lock;
    end else begin
      win      = '{we: m0.we, addr: m0.addr, wdata: m0.wdata, size: m0.size, is_signed: m0.sgn};
      win_lock = m0.lock;
    end
  end

  dmem_addr_check #(
    .BASE      (DMEM_BASE),
    .SIZE_LOG2 (DMEM_SIZE_LOG2),
    .UART      (UART_ADDR)
  ) u_addr_check (
    .addr    (win.addr),
    .size    (win.size),
    .we      (win.we),
    .in_dmem (chk_in_dmem),
    .is_uart (chk_is_uart),
    .err     (chk_err)
  );

  // Only a legal, mapped access reaches the memory; rejected ones still get
  // their gnt pulse but leave the memory interface idle.
  assign issue = gnt_valid && !chk_err && (chk_in_dmem || chk_is_uart);

  assign m0.gnt = gnt_valid && !gnt_port;
  assign m1.gnt = gnt_valid &&  gnt_port;

  assign mem_read        = issue && !win.we;
  assign mem_write       = issue &&  win.we;
  assign mem_addr        = issue ? win.addr : 32'h0;
  assign mem_wdata       = (issue && win.we) ? win.wdata : 32'h0;
  assign mem_load_signed = issue ? win.is_signed : 1'b0;
  assign mem_load_size   = issue ? win.size : 2'b00;
  assign mem_store_size  = issue ? win.size : 2'b00;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      lock_valid <= 1'b0;
      lock_port  <= 1'b0;
      resp_valid <= 1'b0;
      resp_port  <= 1'b0;
      resp_load  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      // A lock survives only while its owner keeps being granted; an owner
      // that drops req loses it on the same edge.
      lock_valid <= gnt_valid && win_lock;
      if (gnt_valid) begin
        rr_ptr    <= ~gnt_port;
        lock_port <= gnt_port;
      end
      resp_valid <= gnt_valid;
      resp_port  <= gnt_port;
      resp_load  <= !win.we;
      resp_err   <= chk_err;
    end
  end

  // Response routing. Load data flows straight from the memory during the
  // response cycle; stores and rejected accesses return zero.
  logic resp_data_ok;
  assign resp_data_ok = resp_valid && resp_load && !resp_err;

  assign m0.rvalid = resp_valid && !resp_port;
  assign m1.rvalid = resp_valid &&  resp_port;
  assign m0.err    = resp_valid && !resp_port && resp_err;
  assign m1.err    = resp_valid &&  resp_port && resp_err;
  assign m0.rdata  = (resp_data_ok && !resp_port) ? mem_rdata : 32'h0;
  assign m1.rdata  = (resp_data_ok &&  resp_port) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_load_signed;
  logic [1:0]  mem_load_size;
  logic [1:0]  mem_store_size;
  logic [31:0] mem_rdata;

  dmem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .m0              (m0_if),
    .m1              (m1_if),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_load_signed (mem_load_signed),
    .mem_load_size   (mem_load_size),
    .mem_store_size  (mem_store_size),
    .mem_rdata       (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  // Memory model: unwritten words return a fixed pattern, writes go to an
  // array, load data appears at the negedge after the issuing posedge.
  logic [31:0]  mem_model [256];
  logic [255:0] written = '0;
  logic [31:0]  rd_word = 32'h0;
  logic [7:0]   uart_byte = 8'h00;

  function automatic logic [31:0] pat(input logic [7:0] idx);
    case (idx)
      8'd4:    return 32'hDEAD_BEEF;   // 0x1000_0010
      8'd8:    return 32'h0000_0A0A;   // 0x1000_0020
      8'd9:    return 32'h0000_0B0B;   // 0x1000_0024
      8'd64:   return 32'h0000_0005;   // 0x1000_0100
      default: return {24'h0, idx};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_read)
      rd_word <= written[mem_addr[9:2]] ? mem_model[mem_addr[9:2]] : pat(mem_addr[9:2]);
    if (mem_write) begin
      if (mem_addr == UART_ADDR)
        uart_byte <= mem_wdata[7:0];
      else if (mem_store_size == SZ_W) begin
        mem_model[mem_addr[9:2]] <= mem_wdata;
        written[mem_addr[9:2]]   <= 1'b1;
      end
    end
  end

  always @(negedge clk) mem_rdata <= rd_word;

  // ---------------------------------------------------------------- drivers
  task automatic drive(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input bit lock);
    if (!port) begin
      m0_if.req = 1'b1; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
      m0_if.size = size; m0_if.sgn = 1'b0; m0_if.lock = lock;
    end else begin
      m1_if.req = 1'b1; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
      m1_if.size = size; m1_if.sgn = 1'b0; m1_if.lock = lock;
    end
  endtask

  task automatic idle_all();
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    m0_if.size = SZ_W; m0_if.sgn = 1'b0; m0_if.lock = 1'b0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    m1_if.size = SZ_W; m1_if.sgn = 1'b0; m1_if.lock = 1'b0;
  endtask

  // Advance one cycle; returns just after the negedge, when both registered
  // responses and negedge memory data are settled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    drive(0, 0, 32'h1000_0010, 32'h0, SZ_W, 0);
    drive(1, 0, 32'h1000_0020, 32'h0, SZ_W, 0);
    @(negedge clk);
    #1;
    checks++;
    if ({m1_if.gnt, m0_if.gnt, mem_read, mem_write} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_gnt got gnt1,gnt0,rd,wr=%b required 0000",
               {m1_if.gnt, m0_if.gnt, mem_read, mem_write});
    end
    checks++;
    if ({m1_if.rvalid, m0_if.rvalid, m1_if.err, m0_if.err} !== 4'b0000 ||
        m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_resp got rv1,rv0,e1,e0=%b rdata0=%h rdata1=%h required 0000/0/0",
               {m1_if.rvalid, m0_if.rvalid, m1_if.err, m0_if.err}, m0_if.rdata, m1_if.rdata);
    end
    idle_all();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    drive(0, 0, 32'h1000_0010, 32'h0, SZ_W, 0);
    #1;
    checks++;
    if ({m1_if.gnt, m0_if.gnt, mem_read, mem_write} !== 4'b0110 ||
        mem_addr !== 32'h1000_0010 || mem_load_size !== SZ_W || mem_load_signed !== 1'b0) begin
      failures++;
      $display("FAIL single_issue got gnt1,gnt0,rd,wr=%b addr=%h lsize=%b lsgn=%b required 0110 10000010 10 0",
               {m1_if.gnt, m0_if.gnt, mem_read, mem_write}, mem_addr, mem_load_size, mem_load_signed);
    end
    step();
    idle_all();
    checks++;
    if (m0_if.rvalid !== 1'b1 || m1_if.rvalid !== 1'b0 || m0_if.err !== 1'b0 ||
        m0_if.rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_resp got rv0=%b rv1=%b err=%b rdata=%h required 1 0 0 deadbeef",
               m0_if.rvalid, m1_if.rvalid, m0_if.err, m0_if.rdata);
    end
    step();
    checks++;
    if (m0_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_one_pulse got rv0=%b required 0", m0_if.rvalid);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [31:0] exp_d0, exp_d1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 32'h1000_0020, 32'h0, SZ_W, 0);
      drive(1, 0, 32'h1000_0024, 32'h0, SZ_W, 0);
      exp_g  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d0 = (i % 2 == 0) ? 32'h0000_0A0A : 32'h0;
      exp_d1 = (i % 2 == 0) ? 32'h0 : 32'h0000_0B0B;
      #1;
      checks++;
      if ({m1_if.gnt, m0_if.gnt} !== exp_g) begin
        failures++;
        $display("FAIL contention_gnt[%0d] got gnt1,gnt0=%b required %b",
                 i, {m1_if.gnt, m0_if.gnt}, exp_g);
      end
      step();
      checks++;
      if ({m1_if.rvalid, m0_if.rvalid} !== exp_g || m0_if.rdata !== exp_d0 ||
          m1_if.rdata !== exp_d1) begin
        failures++;
        $display("FAIL contention_resp[%0d] got rv1,rv0=%b d0=%h d1=%h required %b %h %h",
                 i, {m1_if.rvalid, m0_if.rvalid}, m0_if.rdata, m1_if.rdata, exp_g, exp_d0, exp_d1);
      end
    end
    idle_all();
    step();
  endtask

  task automatic test_lock();
    // One lone m0 access so the round-robin pointer favours m1 next.
    drive(0, 0, 32'h1000_0010, 32'h0, SZ_W, 0);
    step();
    idle_all();
    // Both request; m1 wins by round robin and takes the lock.
    drive(0, 0, 32'h1000_0010, 32'h0, SZ_W, 0);
    drive(1, 0, 32'h1000_0100, 32'h0, SZ_W, 1);
    #1;
    checks++;
    if ({m1_if.gnt, m0_if.gnt, mem_read} !== 3'b101) begin
      failures++;
      $display("FAIL lock_first got gnt1,gnt0,rd=%b required 101", {m1_if.gnt, m0_if.gnt, mem_read});
    end
    step();
    drive(1, 1, 32'h1000_0100, 32'h0000_0006, SZ_W, 0);
    checks++;
    if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== 32'h0000_0005) begin
      failures++;
      $display("FAIL lock_load got rv1=%b rdata=%h required 1 00000005", m1_if.rvalid, m1_if.rdata);
    end
    // Round robin alone would now pick m0; the lock keeps m1.
    #1;
    checks++;
    if ({m1_if.gnt, m0_if.gnt, mem_write} !== 3'b101 || mem_wdata !== 32'h0000_0006) begin
      failures++;
      $display("FAIL lock_second got gnt1,gnt0,wr=%b wdata=%h required 101 00000006",
               {m1_if.gnt, m0_if.gnt, mem_write}, mem_wdata);
    end
    step();
    m1_if.req = 1'b0;
    checks++;
    if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== 32'h0 || m1_if.err !== 1'b0) begin
      failures++;
      $display("FAIL lock_store_ack got rv1=%b rdata=%h err=%b required 1 0 0",
               m1_if.rvalid, m1_if.rdata, m1_if.err);
    end
    #1;
    checks++;
    if ({m1_if.gnt, m0_if.gnt} !== 2'b01) begin
      failures++;
      $display("FAIL lock_release got gnt1,gnt0=%b required 01", {m1_if.gnt, m0_if.gnt});
    end
    step();
    idle_all();
    checks++;
    if (written[64] !== 1'b1 || mem_model[64] !== 32'h0000_0006) begin
      failures++;
      $display("FAIL lock_final_word got written=%b word=%h required 1 00000006",
               written[64], mem_model[64]);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          exp_err;
  } err_vec_t;

  task automatic test_errors();
    err_vec_t v [9];
    logic [2:0] exp_bus;
    logic       rv, er;
    logic [31:0] rd;
    v = '{
      '{0, 0, 32'h1000_0002, SZ_W,  1},   // misaligned word
      '{1, 0, 32'h2000_0000, SZ_W,  1},   // load from write-only UART
      '{0, 1, 32'h3000_0000, SZ_W,  1},   // unmapped store
      '{0, 0, 32'h1001_FFFC, SZ_W,  0},   // last DMEM word
      '{1, 0, 32'h1002_0000, SZ_W,  1},   // one past DMEM
      '{0, 0, 32'h0FFF_FFFC, SZ_W,  1},   // just below DMEM
      '{0, 0, 32'h1000_0001, SZ_H,  1},   // misaligned half
      '{0, 0, 32'h1000_0003, SZ_B,  0},   // byte at odd address
      '{1, 1, 32'h1000_0000, 2'b11, 1}    // reserved size
    };
    for (int i = 0; i < 9; i++) begin
      drive(v[i].port, v[i].we, v[i].addr, 32'h1234_5678, v[i].size, 0);
      exp_bus = {1'b1, !v[i].we && !v[i].exp_err, v[i].we && !v[i].exp_err};
      #1;
      checks++;
      if ({(v[i].port ? m1_if.gnt : m0_if.gnt), mem_read, mem_write} !== exp_bus) begin
        failures++;
        $display("FAIL err_issue[%0d] got gnt,rd,wr=%b required %b", i,
                 {(v[i].port ? m1_if.gnt : m0_if.gnt), mem_read, mem_write}, exp_bus);
      end
      step();
      idle_all();
      rv = v[i].port ? m1_if.rvalid : m0_if.rvalid;
      er = v[i].port ? m1_if.err    : m0_if.err;
      rd = v[i].port ? m1_if.rdata  : m0_if.rdata;
      checks++;
      if (rv !== 1'b1 || er !== v[i].exp_err || (v[i].exp_err && rd !== 32'h0)) begin
        failures++;
        $display("FAIL err_resp[%0d] got rvalid=%b err=%b rdata=%h required 1 %b (rdata 0 if err)",
                 i, rv, er, rd, v[i].exp_err);
      end
    end
  endtask

  task automatic test_uart();
    drive(1, 1, 32'h2000_0000, 32'h0000_0041, SZ_B, 0);
    #1;
    checks++;
    if ({m1_if.gnt, mem_write, mem_read} !== 3'b110 || mem_store_size !== SZ_B ||
        mem_wdata[7:0] !== 8'h41 || mem_addr !== 32'h2000_0000) begin
      failures++;
      $display("FAIL uart_issue got gnt1,wr,rd=%b ssize=%b wdata=%h addr=%h required 110 00 41 20000000",
               {m1_if.gnt, mem_write, mem_read}, mem_store_size, mem_wdata[7:0], mem_addr);
    end
    step();
    idle_all();
    checks++;
    if (m1_if.rvalid !== 1'b1 || m1_if.err !== 1'b0 || m1_if.rdata !== 32'h0 ||
        uart_byte !== 8'h41) begin
      failures++;
      $display("FAIL uart_ack got rv1=%b err=%b rdata=%h uart=%h required 1 0 0 41",
               m1_if.rvalid, m1_if.err, m1_if.rdata, uart_byte);
    end
  endtask

  task automatic test_reset_midflight();
    step();
    // m1 takes a lock and has a response pending when reset hits.
    drive(1, 0, 32'h1000_0024, 32'h0, SZ_W, 1);
    #1;
    checks++;
    if (m1_if.gnt !== 1'b1) begin
      failures++;
      $display("FAIL midflight_gnt got gnt1=%b required 1", m1_if.gnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({m1_if.rvalid, m0_if.rvalid, m1_if.gnt} !== 3'b000) begin
      failures++;
      $display("FAIL midflight_discard got rv1,rv0,gnt1=%b required 000",
               {m1_if.rvalid, m0_if.rvalid, m1_if.gnt});
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 32'h1000_0010, 32'h0, SZ_W, 0);
    drive(1, 0, 32'h1000_0024, 32'h0, SZ_W, 1);
    #1;
    checks++;
    if ({m1_if.gnt, m0_if.gnt} !== 2'b01) begin
      failures++;
      $display("FAIL midflight_post_gnt got gnt1,gnt0=%b required 01", {m1_if.gnt, m0_if.gnt});
    end
    step();
    idle_all();
    checks++;
    if (m0_if.rvalid !== 1'b1 || m1_if.rvalid !== 1'b0 || m0_if.rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL midflight_post_resp got rv0=%b rv1=%b rdata=%h required 1 0 deadbeef",
               m0_if.rvalid, m1_if.rvalid, m0_if.rdata);
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_errors();
    test_uart();
    test_reset_midflight();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL timeout got no completion required finish");
    $fatal(1, "timeout");
  end

endmodule
